// File: rtl/wave_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : wave_capture
// Purpose  : Ping-pong waveform capture buffer. Records a window of
//            2^DEPTH_LOG2 signed samples into the write bank, starting on a
//            rising zero crossing (or after a timeout). The display reads the
//            other, frozen bank. Banks swap only while the display is idle,
//            so a frame never shows a half-written waveform.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk                in   system clock
//   reset              in   synchronous, active-high reset
//   new_sample         in   one-cycle strobe, sample_in valid when high
//   sample_in[15:0]    in   signed two's-complement sample
//   wave_display_idle  in   high while the display is not reading
//   read_index[D-1:0]  in   display read address into the frozen bank
//   read_sample[7:0]   out  registered offset-binary MSBs of the frozen bank
//   buffer_valid       out  high once the first bank swap has occurred
//   armed              out  high while waiting for a trigger
// ----------------------------------------------------------------------------
// Build option
//   WAVE_CAPTURE_TRIGGER_EN  defined   : zero-crossing + timeout trigger
//                            undefined : free-run, capture starts on the
//                                        first sample, TIMEOUT is ignored
// ============================================================================
module wave_capture #(
    parameter int DEPTH_LOG2 = 8,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  new_sample,
    input  logic [15:0]           sample_in,
    input  logic                  wave_display_idle,
    input  logic [DEPTH_LOG2-1:0] read_index,
    output logic [7:0]            read_sample,
    output logic                  buffer_valid,
    output logic                  armed
);

    localparam int c_depth = 1 << DEPTH_LOG2;

    localparam logic [1:0] c_st_armed   = 2'd0;
    localparam logic [1:0] c_st_capture = 2'd1;
    localparam logic [1:0] c_st_full    = 2'd2;

    localparam logic [DEPTH_LOG2-1:0] c_last_addr = {DEPTH_LOG2{1'b1}};
    localparam logic [DEPTH_LOG2-1:0] c_addr_one  = DEPTH_LOG2'(1);

    // Both banks live in one array; the bank select is the address MSB.
    logic [15:0]           r_mem [0:2*c_depth-1];

    logic [1:0]            r_state;
    logic                  r_wr_sel;
    logic [DEPTH_LOG2-1:0] r_wr_addr;
    logic                  r_prev_sign;
    logic                  r_buffer_valid;
    logic                  r_armed;
    logic [7:0]            r_read_sample;

    logic                  w_trigger;
    logic                  w_we;
    logic [DEPTH_LOG2-1:0] w_waddr;
    logic [15:0]           w_rd_word;

    // ------------------------------------------------------------------------
    // Trigger qualification (only meaningful in ARMED on a new_sample)
    // ------------------------------------------------------------------------
`ifdef WAVE_CAPTURE_TRIGGER_EN
    localparam int c_to_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_to_w-1:0] c_to_last = c_to_w'(TIMEOUT - 1);

    logic [c_to_w-1:0] r_to_cnt;

    // Rising zero crossing: previous sample negative, current non-negative.
    // The timeout term forces a capture for silent or DC input.
    assign w_trigger = (r_prev_sign & ~sample_in[15]) | (r_to_cnt == c_to_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_to_cnt <= '0;
        end else if ((r_state == c_st_armed) && new_sample && !w_trigger) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end else if ((r_state == c_st_full) && wave_display_idle) begin
            r_to_cnt <= '0;
        end
    end
`else
    // Free-run: every sample seen while armed starts a window.
    logic w_unused_free_run;
    assign w_unused_free_run = r_prev_sign | (TIMEOUT != 0);
    assign w_trigger         = 1'b1;
`endif

    // ------------------------------------------------------------------------
    // Write port
    // ------------------------------------------------------------------------
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_wr_addr;
        case (r_state)
            c_st_armed: begin
                if (new_sample && w_trigger) begin
                    w_we    = 1'b1;
                    w_waddr = '0;
                end
            end
            c_st_capture: begin
                w_we = new_sample;
            end
            default: begin
                w_we = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_we && !reset) begin
            r_mem[{r_wr_sel, w_waddr}] <= sample_in;
        end
    end

    // ------------------------------------------------------------------------
    // Read port: frozen bank, offset-binary conversion of the upper byte.
    // Until a bank has been completed the frozen bank holds nothing
    // meaningful, so the output parks at mid-scale.
    // ------------------------------------------------------------------------
    assign w_rd_word = r_mem[{~r_wr_sel, read_index}];

    always_ff @(posedge clk) begin
        if (reset || !r_buffer_valid) begin
            r_read_sample <= 8'h80;
        end else begin
            r_read_sample <= {~w_rd_word[15], w_rd_word[14:8]};
        end
    end

    // ------------------------------------------------------------------------
    // Capture state machine
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= c_st_armed;
            r_wr_sel       <= 1'b0;
            r_wr_addr      <= '0;
            r_prev_sign    <= 1'b0;
            r_buffer_valid <= 1'b0;
            r_armed        <= 1'b1;
        end else begin
            // Sign history tracks every sample, whatever the state, so the
            // first sample after a swap can still complete a zero crossing.
            if (new_sample) begin
                r_prev_sign <= sample_in[15];
            end

            case (r_state)
                c_st_armed: begin
                    if (new_sample && w_trigger) begin
                        r_wr_addr <= c_addr_one;
                        r_state   <= c_st_capture;
                        r_armed   <= 1'b0;
                    end
                end
                c_st_capture: begin
                    if (new_sample) begin
                        r_wr_addr <= r_wr_addr + 1'b1;
                        if (r_wr_addr == c_last_addr) begin
                            r_state <= c_st_full;
                        end
                    end
                end
                c_st_full: begin
                    // A sample arriving on the swap cycle is not evaluated
                    // as a trigger; only its sign is recorded above.
                    if (wave_display_idle) begin
                        r_wr_sel       <= ~r_wr_sel;
                        r_buffer_valid <= 1'b1;
                        r_state        <= c_st_armed;
                        r_armed        <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_st_armed;
                    r_armed <= 1'b1;
                end
            endcase
        end
    end

    assign read_sample  = r_read_sample;
    assign buffer_valid = r_buffer_valid;
    assign armed        = r_armed;

endmodule
`default_nettype wire

// File: doc/wave_capture.md
# wave_capture

Ping-pong waveform capture buffer sitting directly downstream of the music player. It consumes the conditioned output sample and its one-cycle new-sample strobe. It records a rising-zero-crossing-triggered window of samples into a write bank while the display side reads a frozen bank. Banks swap only when the display reports it is idle, so the display never shows a torn waveform.

## Interface
- DEPTH_LOG2, 8, log2 of samples per bank (256).
- TIMEOUT, 1024, new-sample pulses in ARMED without a trigger before a forced capture.
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- new_sample  input  1  one-cycle strobe, driven from new_sample_generated.
- sample_in  input  16  signed sample, valid when new_sample is high.
- wave_display_idle  input  1  level; high while the display is not reading (blanking).
- read_index  input  DEPTH_LOG2  display read address into the frozen bank.
- read_sample  output  8  offset-binary value of the frozen bank at read_index.
- buffer_valid  output  1  high once the first bank swap has occurred.
- armed  output  1  high while the state is ARMED.

## Operation
- Two banks of 2^DEPTH_LOG2 x 16 bits each. wr_sel selects the write bank; the read bank is always !wr_sel.
- prev_sign register (reset 0) is updated to sample_in[15] on every new_sample, in any state.
- States are ARMED, CAPTURE and FULL. Reset enters ARMED with wr_sel=0, wr_addr=0 and timeout count=0.
- ARMED:
  - On new_sample, a trigger fires when prev_sign=1 and sample_in[15]=0, or when the timeout count equals TIMEOUT-1.
  - On a trigger, write sample_in at address 0, set wr_addr=1 and go to CAPTURE.
  - Otherwise increment the timeout count.
- CAPTURE:
  - On each new_sample, write to wr_addr and increment it.
  - The write to address 2^DEPTH_LOG2-1 moves the state to FULL. wr_addr wraps to 0.
- FULL:
  - new_sample writes are ignored.
  - In any cycle with wave_display_idle=1: toggle wr_sel, set buffer_valid=1, clear the timeout count and go to ARMED.
- Swap cycle coincident with new_sample: that sample only updates prev_sign. It is not evaluated as a trigger.
- read_sample is registered: {~mem[rd_bank][read_index][15], mem[rd_bank][read_index][14:8]}.
  - So -32768 maps to 0x00, 0 maps to 0x80 and 32767 maps to 0xFF.
- Reset mid-capture abandons the window and clears buffer_valid. Bank contents are undefined after reset.

## Timing
- Reset values: read_sample=8'h80, buffer_valid=0, armed=1.
- read_sample latency: 1 cycle from read_index. It reflects the read bank selected in the same cycle read_index was sampled.
- A sample is written on the clock edge where new_sample=1. The FULL transition takes effect on that same edge.
- Earliest swap: the first edge after entering FULL (wave_display_idle sampled while in FULL). armed rises on that edge.
- Minimum trigger-to-swap: 2^DEPTH_LOG2 new_sample pulses plus 1 cycle.
- Silent or DC input: a forced capture starts on the TIMEOUT-th new_sample after entering ARMED.

## Configuration
- WAVE_CAPTURE_TRIGGER_EN:
  - Defined: the zero-crossing and timeout trigger described above.
  - Undefined: free-run. ARMED triggers on the first new_sample, the timeout counter is not built, and the TIMEOUT parameter is ignored.

## Test plan
- Reset, then read any index -> read_sample=0x80, buffer_valid=0, armed=1.
- Feed the samples -100, +50, then a ramp of 255 samples 1..255, with wave_display_idle=1 -> trigger on +50.
  - After the swap, index 0 reads {~0,50>>8}=0x80 and index 255 reads 0x80 (255>>8=0). buffer_valid=1.
- Feed 0x8000 then 0x7F00 across a trigger -> the stored values read back as 0x00 and 0xFF.
- Constant +1000 input, TIMEOUT=1024 -> capture starts on the 1024th pulse.
  - With TRIGGER_EN undefined, capture starts on the 1st pulse.
- Hold wave_display_idle=0 through FULL while feeding 500 more samples -> no swap, and read data is unchanged.
  - Raise idle -> swap next edge, armed=1.
- Assert reset at wr_addr=100 in CAPTURE -> next cycle armed=1 and buffer_valid=0.
  - A fresh trigger then writes from address 0.
